// File: rtl/mips_pkg.sv
// Shared MIPS register-file types and constants.
// Holds data/index widths, fixed register numbers and the load-extension mode encoding.
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_V0   = 5'd2;

  typedef enum logic [2:0] {
    EXT_WORD   = 3'b000,
    EXT_BYTE_S = 3'b001,
    EXT_BYTE_U = 3'b010,
    EXT_HALF_S = 3'b011,
    EXT_HALF_U = 3'b100
  } ext_mode_t;

endpackage

// File: rtl/mips_gpr_file_if.sv
// Register-file access bundle: two read ports, one write port, $v0 tap.
// master = CPU datapath side, slave = register file side.
interface mips_gpr_file_if;
  import mips_pkg::*;

  logic [REG_IDX_W-1:0] rs_index;
  logic [DATA_W-1:0]    rs_data;
  logic [REG_IDX_W-1:0] rt_index;
  logic [DATA_W-1:0]    rt_data;
  logic [REG_IDX_W-1:0] rd_index;
  logic [DATA_W-1:0]    rd_data;
  logic [2:0]           ext_mode;
  logic                 write_enable;
  logic [DATA_W-1:0]    register_v0;

  modport master (
    output rs_index, rt_index,
    output rd_index, rd_data,
    output ext_mode, write_enable,
    input  rs_data, rt_data,
    input  register_v0
  );

  modport slave (
    input  rs_index, rt_index,
    input  rd_index, rd_data,
    input  ext_mode, write_enable,
    output rs_data, rt_data,
    output register_v0
  );

endinterface

// File: rtl/mips_load_extend.sv
// Combinational load-data extender for LB/LBU/LH/LHU/LW write-back.
// Ports: d_i raw data, mode_i ext_mode_t code, y_o extended word (codes 5..7 = word).
module mips_load_extend
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] d_i,
  input  logic [2:0]        mode_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = d_i;
    case (ext_mode_t'(mode_i))
      EXT_BYTE_S: y_o = {{24{d_i[7]}}, d_i[7:0]};
      EXT_BYTE_U: y_o = {24'b0, d_i[7:0]};
      EXT_HALF_S: y_o = {{16{d_i[15]}}, d_i[15:0]};
      EXT_HALF_U: y_o = {16'b0, d_i[15:0]};
      default:    y_o = d_i;
    endcase
  end

endmodule

// File: rtl/mips_gpr_file.sv
// 32x32 MIPS GPR file: 2 comb read ports, 1 sync write port with load extender.
// Ports: clk, reset (sync, active-high), gpr (slave modport). Option: GPR_WRITE_BYPASS_EN.
module mips_gpr_file
  import mips_pkg::*;
#(
  parameter int unsigned     V0_INDEX    = 2,
  parameter logic [DATA_W-1:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  mips_gpr_file_if.slave gpr
);

  localparam logic [REG_IDX_W-1:0] V0_IDX = V0_INDEX[REG_IDX_W-1:0];

  // Entry 0 is never written; reads of index 0 are forced to zero.
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] wr_data_d;
  logic              wr_en_d;
  logic [DATA_W-1:0] rs_stored;
  logic [DATA_W-1:0] rt_stored;

  mips_load_extend u_ext (
    .d_i    (gpr.rd_data),
    .mode_i (gpr.ext_mode),
    .y_o    (wr_data_d)
  );

  assign wr_en_d = gpr.write_enable && (gpr.rd_index != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else if (wr_en_d) begin
      regs_q[gpr.rd_index] <= wr_data_d;
    end
  end

  assign rs_stored = (gpr.rs_index == REG_ZERO) ? '0
                   : regs_q[gpr.rs_index];
  assign rt_stored = (gpr.rt_index == REG_ZERO) ? '0
                   : regs_q[gpr.rt_index];

`ifdef GPR_WRITE_BYPASS_EN
  logic fwd_en;

  // Write-through: a read of the register being written sees the new value now.
  assign fwd_en = wr_en_d && !reset;

  assign gpr.rs_data = (fwd_en && gpr.rs_index == gpr.rd_index)
                     ? wr_data_d : rs_stored;
  assign gpr.rt_data = (fwd_en && gpr.rt_index == gpr.rd_index)
                     ? wr_data_d : rt_stored;
`else
  assign gpr.rs_data = rs_stored;
  assign gpr.rt_data = rt_stored;
`endif

  // Debug tap is always the stored value, never forwarded.
  assign gpr.register_v0 = (V0_IDX == REG_ZERO) ? '0 : regs_q[V0_IDX];

endmodule

// File: tb/tb_mips_gpr_file.sv
// Self-checking bench for mips_gpr_file.
// Expected values are queued when stimulus is applied and compared on sampling.
module tb_mips_gpr_file;

  localparam int P_RS = 0;
  localparam int P_RT = 1;
  localparam int P_V0 = 2;

  logic clk;
  logic reset;

  int n_chk;
  int n_pass;

  logic [31:0] exp_q [$];
  int          port_q [$];
  string       tag_q [$];

  mips_gpr_file_if bus ();

  mips_gpr_file dut (
    .clk   (clk),
    .reset (reset),
    .gpr   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int port,
                      input logic [31:0] exp);
    tag_q.push_back(tag);
    port_q.push_back(port);
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    string       t;
    int          p;
    logic [31:0] e;
    logic [31:0] g;
    #1;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      p = port_q.pop_front();
      e = exp_q.pop_front();
      case (p)
        P_RS:    g = bus.rs_data;
        P_RT:    g = bus.rt_data;
        default: g = bus.register_v0;
      endcase
      check(t, g, e);
    end
  endtask

  task automatic rd2(input string tag, input logic [4:0] idx,
                     input logic [31:0] exp);
    bus.rs_index = idx;
    bus.rt_index = idx;
    push({tag, "_rs"}, P_RS, exp);
    push({tag, "_rt"}, P_RT, exp);
    drain();
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d,
                    input logic [2:0] m);
    @(negedge clk);
    bus.write_enable = 1'b1;
    bus.rd_index     = idx;
    bus.rd_data      = d;
    bus.ext_mode     = m;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] exp;
  } ext_vec_t;

  ext_vec_t ext_tab [5];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    bus.rs_index     = '0;
    bus.rt_index     = '0;
    bus.rd_index     = '0;
    bus.rd_data      = '0;
    bus.ext_mode     = '0;
    bus.write_enable = 1'b0;

    ext_tab[0] = '{3'b001, 32'hFFFF_FF86};
    ext_tab[1] = '{3'b010, 32'h0000_0086};
    ext_tab[2] = '{3'b011, 32'hFFFF_8086};
    ext_tab[3] = '{3'b100, 32'h0000_8086};
    ext_tab[4] = '{3'b111, 32'h1234_8086};

    // Reset for one cycle, then every index reads zero.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.rs_index = 5'(i);
      bus.rt_index = 5'(31 - i);
      push($sformatf("rst_rs%0d", i), P_RS, 32'h0);
      push($sformatf("rst_rt%0d", 31 - i), P_RT, 32'h0);
      push($sformatf("rst_v0_%0d", i), P_V0, 32'h0);
      drain();
    end

    // Word write and $v0 tap.
    wr(5'd5, 32'hDEAD_BEEF, 3'b000);
    rd2("word_r5", 5'd5, 32'hDEAD_BEEF);
    push("v0_before", P_V0, 32'h0);
    drain();
    wr(5'd2, 32'hDEAD_BEEF, 3'b000);
    push("v0_word", P_V0, 32'hDEAD_BEEF);
    drain();

    // $zero protection.
    wr(5'd0, 32'hFFFF_FFFF, 3'b000);
    rd2("zero", 5'd0, 32'h0);

    // Load-data extension modes.
    foreach (ext_tab[k]) begin
      wr(5'd7, 32'h1234_8086, ext_tab[k].mode);
      rd2($sformatf("ext_m%0d", ext_tab[k].mode), 5'd7,
          ext_tab[k].exp);
    end

    // Independent ports on different registers.
    bus.rs_index = 5'd5;
    bus.rt_index = 5'd7;
    push("dual_rs", P_RS, 32'hDEAD_BEEF);
    push("dual_rt", P_RT, 32'h1234_8086);
    drain();

    // Same-cycle read of the register being written.
    wr(5'd9, 32'h1, 3'b000);
    rd2("r9_init", 5'd9, 32'h1);
    @(negedge clk);
    bus.write_enable = 1'b1;
    bus.rd_index     = 5'd9;
    bus.rd_data      = 32'h2;
    bus.ext_mode     = 3'b000;
    bus.rs_index     = 5'd9;
    bus.rt_index     = 5'd5;
`ifdef GPR_WRITE_BYPASS_EN
    push("same_cyc_rs", P_RS, 32'h2);
`else
    push("same_cyc_rs", P_RS, 32'h1);
`endif
    push("same_cyc_rt", P_RT, 32'hDEAD_BEEF);
    drain();
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    rd2("r9_next", 5'd9, 32'h2);

    // Reset wins over a simultaneous write.
    wr(5'd3, 32'h77, 3'b000);
    rd2("r3_pre", 5'd3, 32'h77);
    @(negedge clk);
    reset            = 1'b1;
    bus.write_enable = 1'b1;
    bus.rd_index     = 5'd3;
    bus.rd_data      = 32'h55;
    bus.ext_mode     = 3'b000;
    @(posedge clk);
    #1;
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    rd2("rst_prio_r3", 5'd3, 32'h0);
    rd2("rst_prio_r5", 5'd5, 32'h0);
    push("rst_prio_v0", P_V0, 32'h0);
    drain();

    // Write with enable low has no effect.
    @(negedge clk);
    bus.rd_index = 5'd4;
    bus.rd_data  = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    rd2("we_low", 5'd4, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
